// File: rtl/inv_expand.sv
// AES-128 reverse-order key schedule: runs the forward expansion up to round key 10,
// then walks back to round key 0 with the inverse recurrence, one key per handshake.

module rotate #(
    parameter int SHIFT = 1,
    parameter int N     = 4,
    parameter int W     = 8
) (
    input  logic [N*W-1:0] a,
    output logic [N*W-1:0] y
);
    // left rotate by SHIFT elements of W bits; element 0 sits in the MSBs
    assign y = {a[N*W-SHIFT*W-1:0], a[N*W-1 -: SHIFT*W]};
endmodule

module subword (
    input  logic [31:0] a,
    output logic [31:0] y
);
    function automatic logic [7:0] gf_dbl(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] acc;
        logic [7:0] cur;
        acc = 8'h00;
        cur = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i])
                acc = acc ^ cur;
            cur = gf_dbl(cur);
        end
        return acc;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

// state | meaning
// IDLE  | waiting for start, outputs quiet
// FWD   | forward expansion from the cipher key towards round key 10
// BWD   | presenting round keys 10..0, one step back per ready
module inv_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         ready,
    output logic [127:0] roundKey,
    output logic         valid,
    output logic [3:0]   round,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;

    state_t       state, state_nx;
    logic [127:0] block, block_nx;
    logic [7:0]   rcon, rcon_nx;
    logic [3:0]   round_q, round_nx;

    logic [31:0] c0, c1, c2, c3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_in, rot_out, sub_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] invxtime(input logic [7:0] x);
        logic [7:0] t;
        t = x ^ 8'h1b;
        return x[0] ? ({1'b0, t[7:1]} | 8'h80) : {1'b0, x[7:1]};
    endfunction

    assign {c0, c1, c2, c3} = block;

    assign p3 = c3 ^ c2;
    assign p2 = c2 ^ c1;
    assign p1 = c1 ^ c0;

    // one S-box path shared by both directions: FWD substitutes c3, BWD substitutes p3
    assign sub_in = (state == BWD) ? p3 : c3;

    rotate #(1, 4, 8) u_rot (
        .a (sub_in),
        .y (rot_out)
    );

    subword u_sub (
        .a (rot_out),
        .y (sub_out)
    );

    assign n0 = c0 ^ sub_out ^ {rcon, 24'h000000};
    assign n1 = c1 ^ n0;
    assign n2 = c2 ^ n1;
    assign n3 = c3 ^ n2;
    assign p0 = c0 ^ sub_out ^ {rcon, 24'h000000};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            block   <= '0;
            rcon    <= 8'h01;
            round_q <= '0;
        end else begin
            state   <= state_nx;
            block   <= block_nx;
            rcon    <= rcon_nx;
            round_q <= round_nx;
        end
    end

    always_comb begin
        state_nx = state;
        block_nx = block;
        rcon_nx  = rcon;
        round_nx = round_q;
        case (state)
            IDLE: begin
                if (start) begin
                    block_nx = key;
                    round_nx = '0;
                    rcon_nx  = 8'h01;
                    state_nx = FWD;
                end
            end
            FWD: begin
                block_nx = {n0, n1, n2, n3};
                round_nx = round_q + 4'd1;
                if (round_q == 4'(NR - 1))
                    state_nx = BWD;
                else
                    rcon_nx = xtime(rcon);
            end
            BWD: begin
                if (ready) begin
                    if (round_q != 4'd0) begin
                        block_nx = {p0, p1, p2, p3};
                        round_nx = round_q - 4'd1;
                        rcon_nx  = invxtime(rcon);
                    end else begin
                        block_nx = '0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign valid    = (state == BWD);
    assign busy     = (state != IDLE);
    assign roundKey = valid ? block : '0;
    assign round    = busy ? round_q : 4'd0;
endmodule

// File: tb/tb_inv_expand.sv
// Directed bench for inv_expand: FIPS-197 A.1 schedule, backpressure, ignored starts,
// mid-run reset and back-to-back schedules, with internal rcon tracking.

module tb_inv_expand;
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic         ready;
    logic [127:0] roundKey;
    logic         valid;
    logic [3:0]   round;
    logic         busy;

    int tests  = 0;
    int failed = 0;

    logic [127:0] exp_rk [0:10];
    logic         known  [0:10];
    logic [7:0]   rtab   [0:9];
    logic [127:0] a1_rk  [0:10];

    inv_expand #(.NR(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .ready    (ready),
        .roundKey (roundKey),
        .valid    (valid),
        .round    (round),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 128'(valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_key"}, roundKey, 128'd0);
        chk({tag, "_round"}, 128'(round), 128'd0);
    endtask

    task automatic pulse_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
        key   = '0;
    endtask

    task automatic fwd_check(input bit inject);
        for (int k = 0; k < 10; k++) begin
            chk("fwd_busy", 128'(busy), 128'd1);
            chk("fwd_valid", 128'(valid), 128'd0);
            chk("fwd_round", 128'(round), 128'(k));
            chk("fwd_rcon", 128'(dut.rcon), 128'(rtab[k]));
            start = inject && (k == 4);
            key   = '0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready low 5 cycles at round 10 then random
    task automatic drain(input int mode, input int inject_r, input int stop_r, input bit b2b);
        int   r     = 10;
        int   hs    = 0;
        int   guard = 0;
        int   hold  = 0;
        logic rdy;
        while (r >= 0 && guard < 300) begin
            guard++;
            chk("bwd_valid", 128'(valid), 128'd1);
            chk("bwd_busy", 128'(busy), 128'd1);
            chk("bwd_round", 128'(round), 128'(r));
            if (known[r])
                chk($sformatf("bwd_key_r%0d", r), roundKey, exp_rk[r]);
            if (r > 0)
                chk("bwd_rcon", 128'(dut.rcon), 128'(rtab[r-1]));
            if (r == stop_r)
                return;
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (r == 10 && hold < 5) begin
                rdy = 1'b0;
                hold++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            ready = rdy;
            start = (r == inject_r) || (b2b && r == 0);
            key   = '0;
            @(negedge clk);
            if (!(b2b && r == 0))
                start = 1'b0;
            if (rdy) begin
                hs++;
                r--;
            end
        end
        chk("drain_bound", 128'(guard < 300), 128'd1);
        chk("handshakes", 128'(hs), 128'd11);
        check_idle("after_r0");
        ready = 1'b0;
    endtask

    task automatic set_a1();
        for (int i = 0; i <= 10; i++) begin
            exp_rk[i] = a1_rk[i];
            known[i]  = 1'b1;
        end
    endtask

    task automatic set_partial(input logic [127:0] k0, input logic [127:0] k10);
        for (int i = 0; i <= 10; i++) begin
            exp_rk[i] = '0;
            known[i]  = 1'b0;
        end
        exp_rk[0]  = k0;
        known[0]   = 1'b1;
        exp_rk[10] = k10;
        known[10]  = 1'b1;
    endtask

    initial begin
        rtab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        a1_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        key   = '0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_rcon", 128'(dut.rcon), 128'h01);
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle_hold");

        // basic A.1 run
        set_a1();
        pulse_start(a1_rk[0]);
        fwd_check(1'b0);
        drain(0, -1, -1, 1'b0);

        // backpressure with random ready
        pulse_start(a1_rk[0]);
        fwd_check(1'b0);
        drain(1, -1, -1, 1'b0);

        // start with key=0 during FWD and BWD is ignored
        pulse_start(a1_rk[0]);
        fwd_check(1'b1);
        drain(0, 5, -1, 1'b0);

        // reset while presenting round 6
        pulse_start(a1_rk[0]);
        fwd_check(1'b0);
        drain(0, -1, 6, 1'b0);
        reset = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        chk("mid_reset_rcon", 128'(dut.rcon), 128'h01);
        reset = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // new key after reset, ending with start held across the round-0 handshake
        set_partial(128'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        pulse_start(128'h000102030405060708090a0b0c0d0e0f);
        fwd_check(1'b0);
        drain(0, -1, -1, 1'b1);

        // start still high in IDLE: accepted, all-zero key
        set_partial(128'h0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        pulse_start(128'h0);
        fwd_check(1'b0);
        drain(0, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
